frame_buffer: RTL and testbench

//  256x256 x 24-bit pixel store; serves the VGA refresh read port (responder side of
//  vc_request/vc_col_address/vc_row_address/vc_read_data).

---
 rtl/frame_buffer.sv | 112 +++++++++++
 tb/tb_frame_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer.sv
// frame_buffer: 256x256 pixel store shared by the VGA refresh reader and the
// pixel-drawing writer. It includes a clear engine that fills the whole buffer
// with one colour.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | write port open; pointer loads honoured; clr_start accepted
// CLEAR | one colour word written per cycle; write port closed
module frame_buffer #(
   parameter int COL_W = 8,
   parameter int ROW_W = 8,
   parameter int PIX_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [COL_W-1:0] vc_col_address,
   input  logic [ROW_W-1:0] vc_row_address,
   input  logic             vc_request,
   output logic [PIX_W-1:0] vc_read_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             wr_auto,
   input  logic [COL_W-1:0] wr_col,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             ptr_load,
   input  logic             clr_start,
   input  logic [PIX_W-1:0] clr_colour,
   output logic             clr_busy
);

   localparam int ADDR_W = ROW_W + COL_W;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic [PIX_W-1:0]    r_colour;
   logic                r_clr_busy;
   logic [PIX_W-1:0]    r_mem [DEPTH];

   logic                w_wr_fire;
   logic [ADDR_W-1:0]   w_explicit_addr;
   logic [ADDR_W-1:0]   w_auto_addr;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [PIX_W-1:0]    w_mem_data;
   logic [ADDR_W-1:0]   w_rd_addr;

   // The write port is open only in IDLE and is closed in the cycle a clear is requested
   assign wr_ready  = !reset && (r_state == IDLE) && !clr_start;
   assign w_wr_fire = wr_valid && wr_ready;

   // A pointer load that arrives together with an auto write redirects that write
   assign w_explicit_addr = {wr_row, wr_col};
   assign w_auto_addr     = ptr_load ? w_explicit_addr : r_ptr;
   assign w_wr_addr       = wr_auto ? w_auto_addr : w_explicit_addr;

   // There is a single memory write port. The clear engine owns it during CLEAR.
   assign w_mem_we   = !reset && ((r_state == CLEAR) || w_wr_fire);
   assign w_mem_addr = (r_state == CLEAR) ? r_clr_addr : w_wr_addr;
   assign w_mem_data = (r_state == CLEAR) ? r_colour : wr_data;

   // The refresh read is combinational and never stalls. It sees the pre-edge contents.
   assign w_rd_addr    = {vc_row_address, vc_col_address};
   assign vc_read_data = vc_request ? r_mem[w_rd_addr] : '0;

   assign clr_busy = r_clr_busy;

   // Memory array: commits at the edge. Reset leaves the contents untouched.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Controller: write pointer, clear sequencing and busy flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_clr_busy <= 1'b0;
         r_ptr      <= '0;
         r_clr_addr <= '0;
      end else if (r_state == IDLE) begin
         if (w_wr_fire && wr_auto) begin
            r_ptr <= w_auto_addr + ADDR_W'(1);
         end else if (ptr_load) begin
            r_ptr <= w_explicit_addr;
         end
         if (clr_start) begin
            r_state    <= CLEAR;
            r_colour   <= clr_colour;
            r_clr_addr <= '0;
            r_clr_busy <= 1'b1;
         end
      end else begin
         r_clr_addr <= r_clr_addr + ADDR_W'(1);
         if (r_clr_addr == {ADDR_W{1'b1}}) begin
            r_state    <= IDLE;
            r_clr_busy <= 1'b0;
            r_ptr      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: randomized and directed checks of frame_buffer against
// an array-based reference model of the pixel store.
module tb_frame_buffer;

   logic        clk;
   logic        reset;
   logic [7:0]  vc_col_address;
   logic [7:0]  vc_row_address;
   logic        vc_request;
   logic [23:0] vc_read_data;
   logic        wr_valid;
   logic        wr_ready;
   logic        wr_auto;
   logic [7:0]  wr_col;
   logic [7:0]  wr_row;
   logic [23:0] wr_data;
   logic        ptr_load;
   logic        clr_start;
   logic [23:0] clr_colour;
   logic        clr_busy;

   frame_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .vc_col_address (vc_col_address),
      .vc_row_address (vc_row_address),
      .vc_request     (vc_request),
      .vc_read_data   (vc_read_data),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_auto        (wr_auto),
      .wr_col         (wr_col),
      .wr_row         (wr_row),
      .wr_data        (wr_data),
      .ptr_load       (ptr_load),
      .clr_start      (clr_start),
      .clr_colour     (clr_colour),
      .clr_busy       (clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model
   logic [23:0] m_mem   [65536];
   bit          m_known [65536];
   logic [15:0] m_ptr;
   bit          m_busy;
   int          m_clr_cnt;
   logic [23:0] m_colour;

   int n_chk;
   int n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply this cycle's inputs to the model, then advance past the rising edge
   task automatic tick();
      logic [15:0] a;
      if (reset) begin
         m_busy    = 1'b0;
         m_ptr     = 16'h0;
         m_clr_cnt = 0;
      end else if (m_busy) begin
         m_mem[m_clr_cnt]   = m_colour;
         m_known[m_clr_cnt] = 1'b1;
         m_clr_cnt++;
         if (m_clr_cnt == 65536) begin
            m_busy = 1'b0;
            m_ptr  = 16'h0;
         end
      end else begin
         if (wr_valid && !clr_start) begin
            if (!wr_auto)      a = {wr_row, wr_col};
            else if (ptr_load) a = {wr_row, wr_col};
            else               a = m_ptr;
            m_mem[a]   = wr_data;
            m_known[a] = 1'b1;
            if (wr_auto)       m_ptr = a + 16'h1;
            else if (ptr_load) m_ptr = {wr_row, wr_col};
         end else if (ptr_load) begin
            m_ptr = {wr_row, wr_col};
         end
         if (clr_start) begin
            m_busy    = 1'b1;
            m_colour  = clr_colour;
            m_clr_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      vc_request = 1'b0; vc_row_address = 8'h0; vc_col_address = 8'h0;
      wr_valid = 1'b0; wr_auto = 1'b0; wr_row = 8'h0; wr_col = 8'h0;
      wr_data = 24'h0; ptr_load = 1'b0; clr_start = 1'b0; clr_colour = 24'h0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] row, input logic [7:0] col,
                         input logic [23:0] exp);
      vc_request = 1'b1; vc_row_address = row; vc_col_address = col;
      @(negedge clk);
      check(tag, vc_read_data, exp);
      tick();
      vc_request = 1'b0;
   endtask

   task automatic wr(input logic au, input logic ld, input logic [7:0] row,
                     input logic [7:0] col, input logic [23:0] d);
      wr_valid = 1'b1; wr_auto = au; ptr_load = ld; wr_row = row; wr_col = col; wr_data = d;
      @(negedge clk);
      check("wr_ready_idle", wr_ready, 1'b1);
      tick();
      wr_valid = 1'b0; wr_auto = 1'b0; ptr_load = 1'b0;
   endtask

   initial begin
      int busy_cnt;
      int rdy_bad;
      bit done;
      logic [15:0] ra;

      n_chk = 0; n_err = 0;
      m_ptr = 16'h0; m_busy = 1'b0; m_clr_cnt = 0; m_colour = 24'h0;
      for (int i = 0; i < 65536; i++) m_known[i] = 1'b0;
      idle_inputs();
      reset = 1'b1;

      // Reset behaviour
      tick();
      @(negedge clk);
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_clr_busy", clr_busy, 1'b0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", wr_ready, 1'b1);
      check("post_rst_busy", clr_busy, 1'b0);
      check("post_rst_rd_idle", vc_read_data, 24'h0);
      tick();

      // Explicit write, read next cycle
      wr(1'b0, 1'b0, 8'd3, 8'd5, 24'h123456);
      rd_chk("explicit_rd", 8'd3, 8'd5, 24'h123456);

      // Same-cycle read and write return the old value
      wr(1'b0, 1'b0, 8'd0, 8'd0, 24'h111111);
      wr_valid = 1'b1; wr_auto = 1'b0; wr_row = 8'd0; wr_col = 8'd0; wr_data = 24'hABCDEF;
      vc_request = 1'b1; vc_row_address = 8'd0; vc_col_address = 8'd0;
      @(negedge clk);
      check("rw_same_old", vc_read_data, 24'h111111);
      tick();
      wr_valid = 1'b0;
      rd_chk("rw_same_new", 8'd0, 8'd0, 24'hABCDEF);

      // Pointer load and auto-increment wrap
      ptr_load = 1'b1; wr_row = 8'd255; wr_col = 8'd254;
      tick();
      ptr_load = 1'b0;
      wr(1'b1, 1'b0, 8'd0, 8'd0, 24'hAAAA01);
      wr(1'b1, 1'b0, 8'd0, 8'd0, 24'hBBBB02);
      wr(1'b1, 1'b0, 8'd0, 8'd0, 24'hCCCC03);
      rd_chk("auto_a", 8'd255, 8'd254, 24'hAAAA01);
      rd_chk("auto_b", 8'd255, 8'd255, 24'hBBBB02);
      rd_chk("auto_c_wrap", 8'd0, 8'd0, 24'hCCCC03);
      wr(1'b1, 1'b0, 8'd0, 8'd0, 24'hDDDD04);
      rd_chk("auto_ptr_is_1", 8'd0, 8'd1, 24'hDDDD04);

      // Pointer load coinciding with an auto write
      wr(1'b1, 1'b1, 8'd1, 8'd200, 24'h0E0E0E);
      wr(1'b1, 1'b0, 8'd9, 8'd9, 24'h0F0F0F);
      rd_chk("load_auto_wr", 8'd1, 8'd200, 24'h0E0E0E);
      rd_chk("load_auto_next", 8'd1, 8'd201, 24'h0F0F0F);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         wr_valid       = 1'($urandom_range(0, 1));
         wr_auto        = 1'($urandom_range(0, 1));
         ptr_load       = ($urandom_range(0, 9) == 0);
         wr_row         = 8'($urandom_range(0, 3));
         wr_col         = 8'($urandom);
         wr_data        = 24'($urandom);
         vc_request     = ($urandom_range(0, 3) != 0);
         vc_row_address = 8'($urandom_range(0, 3));
         vc_col_address = 8'($urandom);
         @(negedge clk);
         check("rnd_ready", wr_ready, 1'b1);
         check("rnd_busy", clr_busy, 1'b0);
         ra = {vc_row_address, vc_col_address};
         if (!vc_request)     check("rnd_rd_idle", vc_read_data, 24'h0);
         else if (m_known[ra]) check("rnd_rd", vc_read_data, m_mem[ra]);
         tick();
      end
      idle_inputs();
      tick();

      // Full clear; a write presented with clr_start is held until the clear ends
      clr_start = 1'b1; clr_colour = 24'h00FF00;
      wr_valid = 1'b1; wr_auto = 1'b0; wr_row = 8'd10; wr_col = 8'd20; wr_data = 24'h5A5A5A;
      @(negedge clk);
      check("clr_start_blocks_wr", wr_ready, 1'b0);
      tick();
      clr_start = 1'b0; clr_colour = 24'h0;
      busy_cnt = 0; rdy_bad = 0; done = 1'b0;
      for (int i = 0; i < 70000 && !done; i++) begin
         @(negedge clk);
         if (!clr_busy) done = 1'b1;
         else begin
            busy_cnt++;
            if (wr_ready) rdy_bad++;
            tick();
         end
      end
      check("clr_done", done, 1'b1);
      check("clr_busy_cycles", busy_cnt, 65536);
      check("clr_ready_low", rdy_bad, 0);
      check("held_wr_ready", wr_ready, 1'b1);
      tick();
      wr_valid = 1'b0;
      rd_chk("clr_0_0", 8'd0, 8'd0, 24'h00FF00);
      rd_chk("clr_128_77", 8'd128, 8'd77, 24'h00FF00);
      rd_chk("clr_255_255", 8'd255, 8'd255, 24'h00FF00);
      rd_chk("held_wr_data", 8'd10, 8'd20, 24'h5A5A5A);
      wr(1'b1, 1'b0, 8'd0, 8'd0, 24'h777777);
      rd_chk("clr_ptr_zero", 8'd0, 8'd0, 24'h777777);

      // Reset in the middle of a clear
      clr_start = 1'b1; clr_colour = 24'hC0FFEE;
      tick();
      clr_start = 1'b0;
      repeat (100) tick();
      reset = 1'b1;
      @(negedge clk);
      check("mid_clr_busy_before", clr_busy, 1'b1);
      check("mid_clr_rst_ready", wr_ready, 1'b0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("mid_clr_rst_busy", clr_busy, 1'b0);
      check("mid_clr_rst_ready_after", wr_ready, 1'b1);
      tick();
      rd_chk("part_clr_0", 8'd0, 8'd0, 24'hC0FFEE);
      rd_chk("part_clr_99", 8'd0, 8'd99, 24'hC0FFEE);
      rd_chk("part_clr_100", 8'd0, 8'd100, 24'h00FF00);
      wr(1'b0, 1'b0, 8'd200, 8'd3, 24'h13579B);
      rd_chk("post_rst_wr", 8'd200, 8'd3, 24'h13579B);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
